probe_event_recorder: RTL and testbench
=======================================

// Module: probe_event_recorder
// PURPOSE
//   Parametrised run controller + change recorder for top-level output probes (LED/JA-style buses).
//   Replaces a fixed-duration bench run with a cycle-bounded RUN window.
//   Records every masked change on the probe bus as a timestamped event into an internal FIFO.
//   Events drain over a valid/ready port. Usable in simulation benches and on-FPGA as a debug tap.
// PARAMETERS
//   WIDTH       16   probe bus width in bits
//   DEPTH       16   event FIFO depth; power of two, >=2
//   TS_WIDTH    20   timestamp/cycle-counter width
//   MAX_CYCLES  500  RUN window length in clocks (10 us at 50 MHz); 0 = unbounded
// PORTS
//   clock      in   1                 system clock; all state on rising edge
//   reset      in   1                 synchronous, active-high; clears all state
//   start      in   1                 pulse: IDLE->RUN; ignored outside IDLE
//   probe      in   WIDTH             observed bus; sampled every clock
//   mask       in   WIDTH             1 = bit participates in change detection
//   ev_valid   out  1                 FIFO head valid (= not empty)
//   ev_ready   in   1                 consumer accepts head when ev_valid & ev_ready
//   ev_ts      out  TS_WIDTH          head event timestamp
//   ev_data    out  WIDTH             head event probe value (full, unmasked)
//   running    out  1                 1 while in RUN
//   done       out  1                 1 while in DONE
//   overflow   out  1                 sticky: at least one event dropped since reset
//   drop_cnt   out  8                 dropped-event count, saturates at 255
// BEHAVIOUR
//   Reset values: ev_valid=0, ev_ts=0, ev_data=0, running=0, done=0, overflow=0, drop_cnt=0.
//   Internal state at reset: FIFO empty, cycle counter 0, state IDLE.
//   FSM IDLE -> RUN on start; RUN -> DONE when counter == MAX_CYCLES-1 (MAX_CYCLES>0).
//   DONE is held until reset; start in RUN/DONE has no effect.
//   On the IDLE->RUN edge: prev <= probe and counter <= 0. No event is generated on this edge.
//   Each RUN clock: event = |((probe ^ prev) & mask); prev <= probe; counter <= counter+1.
//   Counter wraps modulo 2^TS_WIDTH when MAX_CYCLES=0.
//   On event: push {counter, probe}. Latency: ev_valid rises the clock after the sampling edge.
//   Last RUN cycle (counter==MAX_CYCLES-1) still detects and pushes; no detection in IDLE/DONE.
//   FIFO is first-word fall-through; ev_ts/ev_data hold the head value while ev_valid=1.
//   ev_ts/ev_data are don't-care when empty (implementation holds last value).
//   Pop when ev_valid & ev_ready. ev_ready while empty is ignored.
//   Push while full and no pop: event dropped; overflow <= 1; drop_cnt increments, saturating at 255.
//   Push while full with a simultaneous pop: both take effect; no drop, count unchanged.
//   Push + pop while not full and not empty: occupancy unchanged.
//   Draining is allowed in any state, including DONE, so the FIFO can be emptied after the run.
//   Reset mid-RUN: next clock is IDLE with an empty FIFO and all counters and flags cleared.
//   mask changes take effect on the same clock they are applied; unmasked bits never trigger events.
//   If only unmasked bits change, nothing is pushed; the prev register still updates.
// STRUCTURE
//   Shared package: state encoding (ST_IDLE, ST_RUN, ST_DONE), DROP_CNT_W=8.
//   Shared package also holds the event record width EV_W = TS_WIDTH+WIDTH.
//   One sub-module: sync_fifo_fwft (params W, DEPTH), a generic first-word-fall-through FIFO.
//   sync_fifo_fwft outputs full and empty; pointers carry an extra wrap bit.
//   Top level: FSM, cycle counter, prev register, change detect, drop counter.
// TESTING
//   1. reset, start, probe 0x0000->0x0005 at run cycle 3, mask=0xFFFF
//      -> one event {ts=3, data=0x0005}; ev_valid rises at cycle 4.
//   2. mask=0x00FF, change only probe[15:8] -> no event.
//      Then change probe[0] -> event, with ev_data showing all 16 bits.
//   3. DEPTH=16, toggle probe every cycle with ev_ready=0 for 20 cycles
//      -> 16 events held, overflow=1, drop_cnt=4.
//      Then one pop with a simultaneous push -> drop_cnt stays 4.
//   4. MAX_CYCLES=500 -> running for exactly 500 clocks, then done=1.
//      A probe change after done is not recorded; the FIFO still drains to ev_valid=0.
//   5. Assert reset at run cycle 100 with 5 events queued
//      -> next clock: ev_valid=0, running=0, drop_cnt=0.
//      A second start restarts ts at 0.

Source files
------------

// File: rtl/probe_event_recorder_pkg.sv
// Shared definitions for the probe event recorder: run-state encoding,
// drop-counter width and the event record width.
package probe_event_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DROP_CNT_W   = 8;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_TS_WIDTH = 20;
  localparam int EV_W         = DEF_TS_WIDTH + DEF_WIDTH;

  // Event record width for a given timestamp and probe width.
  function automatic int ev_width(input int ts_w, input int w);
    return ts_w + w;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO. Pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
// When empty, the output holds the last word popped (zero after reset).
module sync_fifo_fwft #(
  parameter int W     = 36,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] hold_q;
  logic         do_pop;
  logic         do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A push while full is accepted only if the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];

  // Storage array: data only, never reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Read/write pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Keeps the last popped word visible while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i)       hold_q <= '0;
    else if (do_pop) hold_q <= mem_q[rd_q[AW-1:0]];
  end

endmodule

// File: rtl/probe_event_recorder.sv
// Run controller and change recorder for a probe bus. During a bounded
// RUN window every masked change is stored as {timestamp, probe} in a
// FWFT FIFO that drains over a valid/ready port in any state.
module probe_event_recorder
  import probe_event_recorder_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 20,
  parameter int MAX_CYCLES = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      probe,
  input  logic [WIDTH-1:0]      mask,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [TS_WIDTH-1:0]   ev_ts,
  output logic [WIDTH-1:0]      ev_data,
  output logic                  running,
  output logic                  done,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int                EW       = ev_width(TS_WIDTH, WIDTH);
  localparam logic [TS_WIDTH-1:0] LAST_CNT = TS_WIDTH'(MAX_CYCLES - 1);

  state_e                state_q, state_d;
  logic [TS_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic                  event_w, last_w, pop_w, drop_w;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         head_w;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign event_w = (state_q == ST_RUN) && (|((probe ^ prev_q) & mask));
  assign last_w  = (MAX_CYCLES != 0) && (cnt_q == LAST_CNT);
  assign pop_w   = ev_valid & ev_ready;
  assign drop_w  = event_w & fifo_full & ~pop_w;

  // Run-state, cycle counter and previous-sample registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state: IDLE arms on start, RUN samples and counts, DONE is terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          prev_d  = probe;
        end
      end
      ST_RUN: begin
        prev_d = probe;
        cnt_d  = cnt_q + 1'b1;
        if (last_w) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  // Drop accounting: sticky overflow and a saturating drop count.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop_w) begin
      drop_d = sat_inc(drop_q);
      ovf_d  = 1'b1;
    end
  end

  // Drop accounting registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (event_w),
    .din_i   ({cnt_q, probe}),
    .pop_i   (pop_w),
    .dout_o  (head_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_ts    = head_w[EW-1:WIDTH];
  assign ev_data  = head_w[WIDTH-1:0];
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_probe_event_recorder.sv
// Directed bench for probe_event_recorder with default parameters
// (WIDTH=16, DEPTH=16, TS_WIDTH=20, MAX_CYCLES=500).
module tb_probe_event_recorder;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] probe;
  logic [15:0] mask;
  logic        ev_valid;
  logic        ev_ready;
  logic [19:0] ev_ts;
  logic [15:0] ev_data;
  logic        running;
  logic        done;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int errors  = 0;
  int checks  = 0;
  int run_obs = 0;

  probe_event_recorder dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .probe    (probe),
    .mask     (mask),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ts    (ev_ts),
    .ev_data  (ev_data),
    .running  (running),
    .done     (done),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (running === 1'b1) run_obs++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; probe = 16'h0000; mask = 16'hFFFF; ev_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_ts",    32'(ev_ts),    32'd0);
    chk("rst_ev_data",  32'(ev_data),  32'd0);
    chk("rst_running",  32'(running),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // 1: single change at run cycle 3
    start = 1'b1; step(); start = 1'b0;          // counter 0
    chk("t1_running", 32'(running), 32'd1);
    step(); step(); step();                       // counter 3
    chk("t1_no_ev_yet", 32'(ev_valid), 32'd0);
    probe = 16'h0005; step();                     // sampled at counter 3
    chk("t1_ev_valid", 32'(ev_valid), 32'd1);
    chk("t1_ev_ts",    32'(ev_ts),    32'd3);
    chk("t1_ev_data",  32'(ev_data),  32'h0005);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;     // counter now 5
    chk("t1_drained",  32'(ev_valid), 32'd0);
    chk("t1_hold_ts",  32'(ev_ts),    32'd3);

    // 2: masked-out change is ignored, masked-in change records full bus
    mask = 16'h00FF; probe = 16'h0505; step();    // counter 5 -> 6
    chk("t2_unmasked_no_ev", 32'(ev_valid), 32'd0);
    probe = 16'h0504; step();                     // event at counter 6
    chk("t2_ev_valid", 32'(ev_valid), 32'd1);
    chk("t2_ev_ts",    32'(ev_ts),    32'd6);
    chk("t2_ev_data",  32'(ev_data),  32'h0504);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;     // counter now 8
    chk("t2_drained",  32'(ev_valid), 32'd0);

    // 3: 20 events into a 16-deep FIFO with no draining
    mask = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin             // events at counter 8..27
      probe = ~probe; step();
    end
    chk("t3_ev_valid", 32'(ev_valid), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("t3_head_ts",  32'(ev_ts),    32'd8);
    chk("t3_head_data", 32'(ev_data), 32'hFAFB);
    ev_ready = 1'b1; probe = ~probe; step(); ev_ready = 1'b0;  // pop + push at counter 28
    chk("t3_pp_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("t3_pp_head_ts",  32'(ev_ts),    32'd9);
    ev_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("t3_tail_valid", 32'(ev_valid), 32'd1);
    chk("t3_tail_ts",    32'(ev_ts),    32'd28);
    step(); ev_ready = 1'b0;                       // counter now 45
    chk("t3_empty", 32'(ev_valid), 32'd0);

    // 5: reset at run cycle 100 with 5 events queued
    for (int i = 0; i < 50; i++) step();          // counter 95
    for (int i = 0; i < 5; i++) begin              // events at counter 95..99
      probe = ~probe; step();
    end
    chk("t5_queued_valid", 32'(ev_valid), 32'd1);
    chk("t5_queued_ts",    32'(ev_ts),    32'd95);
    chk("t5_still_run",    32'(running),  32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_valid",    32'(ev_valid), 32'd0);
    chk("t5_rst_running",  32'(running),  32'd0);
    chk("t5_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t5_rst_overflow", 32'(overflow), 32'd0);
    step();
    chk("t5_idle_no_ev",   32'(ev_valid), 32'd0);

    // 4: fresh run restarts timestamps at 0 and lasts exactly 500 clocks
    run_obs = 0;
    start = 1'b1; step(); start = 1'b0;          // counter 0
    probe = ~probe; step();                        // event at counter 0
    chk("t4_restart_ts", 32'(ev_ts),    32'd0);
    chk("t4_restart_v",  32'(ev_valid), 32'd1);
    start = 1'b1; ev_ready = 1'b1; step(); ev_ready = 1'b0; start = 1'b0;
    chk("t4_start_in_run", 32'(running), 32'd1);
    chk("t4_popped",     32'(ev_valid), 32'd0);
    for (int g = 0; g < 600 && done !== 1'b1; g++) begin
      if (run_obs == 498 || run_obs == 500) probe = ~probe;  // counter 497 and 499
      step();
    end
    chk("t4_done",       32'(done),     32'd1);
    chk("t4_run_clocks", 32'(run_obs),  32'd500);
    chk("t4_not_running", 32'(running), 32'd0);
    chk("t4_head_ts",    32'(ev_ts),    32'd497);
    probe = ~probe; step();
    ev_ready = 1'b1; step();
    chk("t4_last_valid", 32'(ev_valid), 32'd1);
    chk("t4_last_ts",    32'(ev_ts),    32'd499);
    step(); ev_ready = 1'b0;
    chk("t4_drained",    32'(ev_valid), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("t4_done_held",  32'(done),     32'd1);
    chk("t4_start_ign",  32'(running),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
